sd_cmd_tx: RTL and testbench



---
 rtl/sd_pkg.sv | 30 +++
 rtl/sd_crc7.sv | 37 +++
 rtl/sd_cmd_tx.sv | 153 +++++++++++++++
 tb/tb_sd_cmd_tx.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// Shared SD CMD-line definitions: frame geometry, CRC7 polynomial, TX states.
package sd_pkg;

  localparam int SD_CMD_FRAME_LEN = 48;
  localparam int SD_CRC7_LEN      = 7;
  // Bits 47..8 (start, transmission, index, argument) are the CRC-covered part.
  localparam int SD_CMD_BODY_LEN  = SD_CMD_FRAME_LEN - SD_CRC7_LEN - 1;

  localparam logic [6:0] SD_CRC7_POLY = 7'h09;  // x^7 + x^3 + 1

  localparam logic SD_START_BIT   = 1'b0;
  localparam logic SD_TX_BIT_HOST = 1'b1;  // transmission bit: host -> card
  localparam logic SD_END_BIT     = 1'b1;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_SEND,
    TX_CRC,
    TX_STOP,
    TX_GAP
  } sd_tx_state_e;

  // One serial CRC7 step: feedback is the incoming bit xor the current MSB.
  function automatic logic [6:0] sd_crc7_step(input logic [6:0] crc, input logic bit_in);
    logic fb;
    fb = bit_in ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? SD_CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 accumulator for SD CMD frames; usable on both TX and RX paths.
module sd_crc7
  import sd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       shift_en,
  input  logic       bit_in,
  output logic [6:0] crc
);

  logic [6:0] crc_q;
  logic [6:0] crc_d;

  // Next CRC: clear wins over shifting; otherwise hold.
  always_comb begin
    crc_d = crc_q;
    if (clear) begin
      crc_d = 7'h00;
    end else if (shift_en) begin
      crc_d = sd_crc7_step(crc_q, bit_in);
    end
  end

  // CRC register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      crc_q <= 7'h00;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/sd_cmd_tx.sv
// Host SD command transmitter: serialises start/tx/index/arg, appends CRC7 and
// end bit, then holds CMD high for NCC_CYCLES en-cycles before releasing it.
module sd_cmd_tx
  import sd_pkg::*;
#(
  parameter int NCC_CYCLES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        start,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  output logic        sd_cmd_out,
  output logic        sd_cmd_oe,
  output logic        busy,
  output logic        finished
);

  // One counter serves the body, CRC and gap phases; size it for the longest.
  localparam int CNT_MAX = (NCC_CYCLES > SD_CMD_BODY_LEN) ? NCC_CYCLES : SD_CMD_BODY_LEN;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] BODY_LAST = CNT_W'(SD_CMD_BODY_LEN - 1);
  localparam logic [CNT_W-1:0] CRC_LAST  = CNT_W'(SD_CRC7_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(NCC_CYCLES - 1);

  sd_tx_state_e               state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [SD_CMD_BODY_LEN-1:0] shreg_q, shreg_d;
  logic                       finished_q, finished_d;

  logic       crc_clear;
  logic       crc_shift;
  logic [6:0] crc_val;
  logic [2:0] crc_sel;

  // The CRC only sees body bits; during the CRC phase it is frozen and the
  // counter picks which bit goes out, so no separate copy is needed.
  sd_crc7 u_crc7 (
    .clk      (clk),
    .reset    (reset),
    .clear    (crc_clear),
    .shift_en (crc_shift),
    .bit_in   (shreg_q[SD_CMD_BODY_LEN-1]),
    .crc      (crc_val)
  );

  // Next-state and output decode; outputs depend only on registered state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    finished_d = finished_q;
    crc_clear  = 1'b0;
    crc_shift  = 1'b0;
    crc_sel    = 3'(SD_CRC7_LEN - 1) - cnt_q[2:0];
    sd_cmd_out = 1'b1;
    sd_cmd_oe  = 1'b0;
    busy       = 1'b0;

    case (state_q)
      TX_IDLE: begin
        // Acceptance does not wait for en: the start bit is presented next cycle.
        if (start) begin
          state_d    = TX_SEND;
          cnt_d      = '0;
          shreg_d    = {SD_START_BIT, SD_TX_BIT_HOST, cmd_index, cmd_arg};
          crc_clear  = 1'b1;
          finished_d = 1'b0;
        end
      end

      TX_SEND: begin
        sd_cmd_out = shreg_q[SD_CMD_BODY_LEN-1];
        sd_cmd_oe  = 1'b1;
        busy       = 1'b1;
        if (en) begin
          crc_shift = 1'b1;
          shreg_d   = {shreg_q[SD_CMD_BODY_LEN-2:0], 1'b0};
          if (cnt_q == BODY_LAST) begin
            state_d = TX_CRC;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      TX_CRC: begin
        sd_cmd_out = crc_val[crc_sel];
        sd_cmd_oe  = 1'b1;
        busy       = 1'b1;
        if (en) begin
          if (cnt_q == CRC_LAST) begin
            state_d = TX_STOP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      TX_STOP: begin
        sd_cmd_out = SD_END_BIT;
        sd_cmd_oe  = 1'b1;
        busy       = 1'b1;
        if (en) begin
          state_d = TX_GAP;
          cnt_d   = '0;
        end
      end

      TX_GAP: begin
        sd_cmd_out = 1'b1;
        sd_cmd_oe  = 1'b1;
        busy       = 1'b1;
        if (en) begin
          if (cnt_q == GAP_LAST) begin
            state_d    = TX_IDLE;
            cnt_d      = '0;
            finished_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = TX_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers; reset aborts any frame in progress on the next edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= TX_IDLE;
      cnt_q      <= '0;
      shreg_q    <= '0;
      finished_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      finished_q <= finished_d;
    end
  end

  assign finished = finished_q;

endmodule

// File: tb/tb_sd_cmd_tx.sv
// Directed bench for sd_cmd_tx: frames checked against hand-computed values.
module tb_sd_cmd_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        start;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        sd_cmd_out;
  logic        sd_cmd_oe;
  logic        busy;
  logic        finished;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  sd_cmd_tx #(.NCC_CYCLES(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .start      (start),
    .cmd_index  (cmd_index),
    .cmd_arg    (cmd_arg),
    .sd_cmd_out (sd_cmd_out),
    .sd_cmd_oe  (sd_cmd_oe),
    .busy       (busy),
    .finished   (finished)
  );

  // Single comparison point: counts, and reports any mismatch.
  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a start with en low (acceptance must not depend on en).
  task automatic do_start(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                          input bit keep);
    cmd_index = idx;
    cmd_arg   = arg;
    start     = 1'b1;
    en        = 1'b0;
    tick();
    if (!keep) begin
      start     = 1'b0;
      cmd_index = 6'($urandom);
      cmd_arg   = $urandom;
    end
    check_val({tag, " latency busy"}, 64'(busy), 64'd1);
    check_val({tag, " start bit"}, 64'(sd_cmd_out), 64'd0);
    check_val({tag, " finished cleared"}, 64'(finished), 64'd0);
  endtask

  // Drive en every 'period' cycles while busy and capture the line on en cycles.
  task automatic run_frame(input int period, input int stall_at, input int mid_start_at,
                           input int abort_at, input bit hold_start,
                           output logic [47:0] frame, output int n_en, output int cycles,
                           output int line_err, output bit aborted);
    logic cur;
    int   phase;
    bit   en_now;
    frame    = '1;
    n_en     = 0;
    cycles   = 0;
    line_err = 0;
    aborted  = 1'b0;
    cur      = sd_cmd_out;
    while (busy && cycles < 2000) begin
      phase  = cycles % period;
      en_now = (phase == period - 1);
      if (phase == 0) cur = sd_cmd_out;
      else if (sd_cmd_out !== cur) line_err++;
      if (sd_cmd_oe !== 1'b1) line_err++;
      if (abort_at >= 0 && n_en == abort_at && phase == 0) begin
        reset = 1'b1;
        en    = 1'b0;
        tick();
        reset   = 1'b0;
        aborted = 1'b1;
        break;
      end
      start = hold_start || (cycles == mid_start_at);
      if (start && !hold_start) begin
        cmd_index = 6'd0;
        cmd_arg   = 32'd0;
      end
      if (en_now && n_en == stall_at) begin
        en = 1'b0;
        for (int k = 0; k < 100; k++) begin
          tick();
          if (sd_cmd_out !== cur || sd_cmd_oe !== 1'b1 || busy !== 1'b1) line_err++;
        end
      end
      en = en_now;
      if (en_now) begin
        if (n_en < 48) frame[47-n_en] = sd_cmd_out;
        else if (sd_cmd_out !== 1'b1) line_err++;
        n_en++;
      end
      tick();
      cycles++;
    end
    en    = 1'b0;
    start = hold_start;
  endtask

  task automatic check_done(input string tag);
    check_val({tag, " oe released"}, 64'(sd_cmd_oe), 64'd0);
    check_val({tag, " idle high"}, 64'(sd_cmd_out), 64'd1);
    check_val({tag, " finished"}, 64'(finished), 64'd1);
  endtask

  logic [47:0] frame;
  int          n_en, cycles, line_err;
  bit          aborted;

  initial begin
    reset     = 1'b1;
    en        = 1'b0;
    start     = 1'b0;
    cmd_index = 6'd0;
    cmd_arg   = 32'd0;
    tick();
    tick();
    check_val("reset sd_cmd_out", 64'(sd_cmd_out), 64'd1);
    check_val("reset sd_cmd_oe", 64'(sd_cmd_oe), 64'd0);
    check_val("reset busy", 64'(busy), 64'd0);
    check_val("reset finished", 64'(finished), 64'd0);
    reset = 1'b0;
    tick();

    // CMD0, en every cycle.
    do_start("cmd0", 6'd0, 32'h0000_0000, 1'b0);
    run_frame(1, -1, -1, -1, 1'b0, frame, n_en, cycles, line_err, aborted);
    check_val("cmd0 frame", 64'(frame), 64'h4000_0000_0095);
    check_val("cmd0 en count", 64'(n_en), 64'd56);
    check_val("cmd0 busy cycles", 64'(cycles), 64'd56);
    check_val("cmd0 line errors", 64'(line_err), 64'd0);
    check_done("cmd0");
    tick();
    tick();
    check_val("cmd0 finished holds", 64'(finished), 64'd1);

    // CMD8, en every 4th cycle: each bit held exactly 4 cycles.
    do_start("cmd8", 6'd8, 32'h0000_01AA, 1'b0);
    run_frame(4, -1, -1, -1, 1'b0, frame, n_en, cycles, line_err, aborted);
    check_val("cmd8 frame", 64'(frame), 64'h4800_0001_AA87);
    check_val("cmd8 busy cycles", 64'(cycles), 64'd224);
    check_val("cmd8 hold errors", 64'(line_err), 64'd0);
    check_done("cmd8");

    // CMD17 with a CMD0 start pulsed mid-frame, which must be ignored.
    do_start("cmd17", 6'd17, 32'h0000_0000, 1'b0);
    run_frame(2, -1, 10, -1, 1'b0, frame, n_en, cycles, line_err, aborted);
    check_val("cmd17 frame", 64'(frame), 64'h5100_0000_0055);
    check_val("cmd17 busy cycles", 64'(cycles), 64'd112);
    check_done("cmd17");
    tick();
    check_val("cmd17 no restart", 64'(busy), 64'd0);

    // Reset during bit 20 of CMD8, then a clean CMD0.
    do_start("abort", 6'd8, 32'h0000_01AA, 1'b0);
    run_frame(4, -1, -1, 20, 1'b0, frame, n_en, cycles, line_err, aborted);
    check_val("abort taken", 64'(aborted), 64'd1);
    check_val("abort oe", 64'(sd_cmd_oe), 64'd0);
    check_val("abort out", 64'(sd_cmd_out), 64'd1);
    check_val("abort busy", 64'(busy), 64'd0);
    en = 1'b1;
    tick();
    tick();
    en = 1'b0;
    check_val("abort stays idle", 64'(busy), 64'd0);
    do_start("post-abort", 6'd0, 32'h0000_0000, 1'b0);
    run_frame(1, -1, -1, -1, 1'b0, frame, n_en, cycles, line_err, aborted);
    check_val("post-abort frame", 64'(frame), 64'h4000_0000_0095);

    // Back-to-back: start held high throughout.
    do_start("b2b1", 6'd17, 32'h0000_0000, 1'b1);
    run_frame(1, -1, -1, -1, 1'b1, frame, n_en, cycles, line_err, aborted);
    check_val("b2b first frame", 64'(frame), 64'h5100_0000_0055);
    check_val("b2b busy low", 64'(busy), 64'd0);
    check_val("b2b finished pulse", 64'(finished), 64'd1);
    cmd_index = 6'd0;
    cmd_arg   = 32'd0;
    tick();
    start = 1'b0;
    check_val("b2b second busy", 64'(busy), 64'd1);
    check_val("b2b finished cleared", 64'(finished), 64'd0);
    check_val("b2b second start bit", 64'(sd_cmd_out), 64'd0);
    run_frame(1, -1, -1, -1, 1'b0, frame, n_en, cycles, line_err, aborted);
    check_val("b2b second frame", 64'(frame), 64'h4000_0000_0095);

    // en low for 100 cycles in the CRC phase (frame bit index 42).
    do_start("stall", 6'd8, 32'h0000_01AA, 1'b0);
    run_frame(1, 42, -1, -1, 1'b0, frame, n_en, cycles, line_err, aborted);
    check_val("stall frame", 64'(frame), 64'h4800_0001_AA87);
    check_val("stall en count", 64'(n_en), 64'd56);
    check_val("stall frozen errors", 64'(line_err), 64'd0);
    check_done("stall");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
